// File: rtl/dff_reg_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : dff_reg_arbiter_if
// Description : Bundle of requester-side and register-side signals for
//               dff_reg_arbiter.
//               master modport : requester side (drives req/data)
//               slave  modport : arbiter side   (drives gnt/ack/q/status)
//   req   [N]        level request per requester, four-phase
//   data  [N*WIDTH]  flattened data, requester i at [i*WIDTH +: WIDTH]
//   gnt   [N]        one-hot grant
//   ack   [N]        one-cycle write confirmation
//   q     [WIDTH]    shared register contents
//   busy             arbiter in GRANT or HOLD
//   owner [clog2(N)] current or last owner index
//   err              one-cycle timeout pulse
// Revision    : 1.0 - initial release
// ============================================================================
interface dff_reg_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int N     = 4
);
    localparam int c_owner_w = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]         req;
    logic [N*WIDTH-1:0]   data;
    logic [N-1:0]         gnt;
    logic [N-1:0]         ack;
    logic [WIDTH-1:0]     q;
    logic                 busy;
    logic [c_owner_w-1:0] owner;
    logic                 err;

    modport master (
        output req, data,
        input  gnt, ack, q, busy, owner, err
    );

    modport slave (
        input  req, data,
        output gnt, ack, q, busy, owner, err
    );
endinterface
`default_nettype wire

// File: rtl/dff_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dff_reg_arbiter
// Description : Round-robin arbiter and write sequencer sharing one WIDTH-bit
//               register among N four-phase req/gnt requesters. The granted
//               requester's data is written in the GRANT cycle and confirmed
//               by a one-cycle ack pulse.
//   clk  : rising-edge clock
//   rst  : asynchronous, active-low reset
//   bus  : dff_reg_arbiter_if.slave (req, data in; gnt, ack, q, busy,
//          owner, err out)
// Optional feature macro : ARB_TIMEOUT_EN
//   When defined, an owner holding HOLD for TIMEOUT cycles is forced off,
//   err pulses, and its request is masked until it drops. When undefined,
//   err is tied low and HOLD lasts until the owner drops req.
// Revision    : 1.0 - initial release
// ============================================================================
module dff_reg_arbiter #(
    parameter int WIDTH   = 8,
    parameter int N       = 4,
    parameter int TIMEOUT = 15
) (
    input  wire logic          clk,
    input  wire logic          rst,
    dff_reg_arbiter_if.slave   bus
);

    localparam int             c_owner_w = $clog2(N);
    localparam logic [N-1:0]   c_one     = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t                 r_state;
    logic [N-1:0]           r_gnt;
    logic [N-1:0]           r_ack;
    logic [WIDTH-1:0]       r_q;
    logic                   r_busy;
    logic [c_owner_w-1:0]   r_owner;
    logic [c_owner_w-1:0]   r_ptr;

    logic [N-1:0]           w_eligible;
    logic                   w_found;
    logic [c_owner_w-1:0]   w_pick;
    logic [N-1:0]           w_pick_oh;
    int                     w_idx;
    logic                   w_owner_req;
    logic [WIDTH-1:0]       w_owner_data;
    logic [c_owner_w-1:0]   w_next_ptr;

`ifdef ARB_TIMEOUT_EN
    localparam int c_cnt_w = $clog2(TIMEOUT + 1);

    logic                   r_err;
    logic [N-1:0]           r_mask;
    logic [c_cnt_w-1:0]     r_cnt;
    logic                   w_timeout;

    // A forced-off requester stays masked until it drops its request.
    assign w_eligible = bus.req & ~r_mask;
    assign w_timeout  = (r_cnt == c_cnt_w'(TIMEOUT - 1));
    assign bus.err    = r_err;
`else
    assign w_eligible = bus.req;
    assign bus.err    = 1'b0;
`endif

    // First eligible requester searching ptr, ptr+1, ... wrapping at N.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = 0;
        for (int off = 0; off < N; off++) begin
            w_idx = int'(r_ptr) + off;
            if (w_idx >= N) begin
                w_idx = w_idx - N;
            end
            if (!w_found && w_eligible[w_idx]) begin
                w_found = 1'b1;
                w_pick  = c_owner_w'(w_idx);
            end
        end
    end

    assign w_pick_oh    = c_one << w_pick;
    assign w_owner_req  = bus.req[r_owner];
    assign w_owner_data = bus.data[int'(r_owner) * WIDTH +: WIDTH];
    // Released owner gets the lowest priority next time round.
    assign w_next_ptr   = (r_owner == c_owner_w'(N - 1)) ? '0 : (r_owner + 1'b1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_ack   <= '0;
            r_q     <= '0;
            r_busy  <= 1'b0;
            r_owner <= '0;
            r_ptr   <= '0;
`ifdef ARB_TIMEOUT_EN
            r_err   <= 1'b0;
            r_mask  <= '0;
            r_cnt   <= '0;
`endif
        end else begin
            r_ack <= '0;
`ifdef ARB_TIMEOUT_EN
            r_err  <= 1'b0;
            r_mask <= r_mask & bus.req;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_gnt   <= w_pick_oh;
                        r_owner <= w_pick;
                        r_busy  <= 1'b1;
                        r_state <= ST_GRANT;
                    end
                end

                ST_GRANT: begin
                    // Write happens regardless of whether req has dropped.
                    r_q     <= w_owner_data;
                    r_ack   <= r_gnt;
                    r_state <= ST_HOLD;
`ifdef ARB_TIMEOUT_EN
                    r_cnt   <= '0;
`endif
                end

                ST_HOLD: begin
                    if (!w_owner_req) begin
                        r_gnt   <= '0;
                        r_busy  <= 1'b0;
                        r_ptr   <= w_next_ptr;
                        r_state <= ST_IDLE;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (w_timeout) begin
                        r_gnt   <= '0;
                        r_busy  <= 1'b0;
                        r_ptr   <= w_next_ptr;
                        r_state <= ST_IDLE;
                        r_err   <= 1'b1;
                        r_mask  <= (r_mask & bus.req) | r_gnt;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                    end
`endif
                end

                default: begin
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt   = r_gnt;
    assign bus.ack   = r_ack;
    assign bus.q     = r_q;
    assign bus.busy  = r_busy;
    assign bus.owner = r_owner;

endmodule
`default_nettype wire

// File: doc/dff_reg_arbiter.md
# dff_reg_arbiter

Round-robin arbiter and write sequencer that shares one WIDTH-bit positive-edge register among N requesters. Each requester runs a four-phase req/gnt handshake. The granted requester's data is captured into the shared register, and an ack pulse confirms the write. The block sits in front of the team's posedge-clocked, async-active-low-reset flip-flop storage and is the only agent that drives that storage's load path.

## Interface
- WIDTH, 8, width of the shared register and of each requester's data word
- N, 4, number of requesters (2..8)
- TIMEOUT, 15, maximum HOLD cycles before a forced release (used only with ARB_TIMEOUT_EN)

- clk  input  1  clock; all state changes on the rising edge
- rst  input  1  reset, asynchronous, active-low
- req  input  N  request per requester; level, four-phase
- data  input  N*WIDTH  flattened data; requester i uses bits [i*WIDTH +: WIDTH]
- gnt  output  N  one-hot grant; all zero when no requester is served
- ack  output  N  one-cycle pulse: the owner's data was written to q
- q  output  WIDTH  shared register contents
- busy  output  1  high in GRANT and HOLD
- owner  output  $clog2(N)  index of the current or last owner
- err  output  1  one-cycle timeout pulse; tied 0 without ARB_TIMEOUT_EN

## Operation
- Reset (rst low, takes effect immediately, no clock needed): state IDLE, gnt=0, ack=0, q=0, busy=0, owner=0, err=0, pointer ptr=0, timeout counter=0.
- FSM states: IDLE, GRANT, HOLD.
- IDLE
  - If any req bit is high, select the first requester with req high, searching ptr, ptr+1, … mod N.
  - Set gnt to that requester's one-hot bit and owner to its index; go to GRANT.
  - With no request, stay in IDLE.
- GRANT (exactly one cycle)
  - q <= data of owner; ack[owner] pulses for this edge only; go to HOLD.
  - The write occurs even if req[owner] has already dropped.
- HOLD
  - gnt is held.
  - When req[owner] is low at an edge: gnt <= 0, ptr <= (owner+1) mod N, go to IDLE.
- Fairness: after owner k is released, k has the lowest priority in the next arbitration.
- q changes only in GRANT; it holds its value in every other state.
- Requests from non-owners are ignored while busy; they are not latched and must be held until granted.

## Timing
- req rises before edge n (IDLE) → gnt and busy high after edge n.
- q updated and ack high after edge n+1; ack low again after edge n+2.
- req[owner] low before edge m (HOLD) → gnt and busy low after edge m.
- The earliest next grant is after edge m+1. The minimum grant-to-grant spacing is 3 cycles.
- Only one ack bit can be high at a time; gnt is zero or one-hot at all times.
- Reset asserted in any state, including mid-GRANT: all outputs take their reset values asynchronously. After release, the first edge is an IDLE arbitration with ptr=0.

## Configuration
- ARB_TIMEOUT_EN defined:
  - A counter clears on entry to HOLD and increments each cycle in HOLD.
  - If it reaches TIMEOUT while req[owner] is still high: force release (gnt <= 0, ptr advances, go to IDLE) and pulse err for one cycle.
  - The forced-off requester must drop req and re-request to be served again. Its still-high req is masked from arbitration until that req goes low.
- ARB_TIMEOUT_EN undefined: no counter, no mask; err is tied to 0 and HOLD lasts until req drops.

## Test plan
- Reset check: rst low mid-stream, no clock → gnt=0, ack=0, q=0, busy=0, owner=0, err=0.
- Single requester:
  - Stimulus: req=4'b0100, data[2]=8'hA5.
  - Response: gnt=4'b0100 one cycle later, q=8'hA5 and ack=4'b0100 one cycle after that.
  - Drop req → gnt=0 after the next edge.
- Round-robin: req=4'b1111 held, each owner drops req one cycle after its ack → owners granted in order 0,1,2,3,0, and q takes each owner's data in turn.
- Early drop: req[1] pulsed for one cycle only → still granted; q=data[1], ack[1] pulses, and release follows on the next edge.
- Reset mid-HOLD with owner=3: rst low → immediate reset values; after release, req=4'b1001 → requester 0 is granted (ptr=0).
- With ARB_TIMEOUT_EN:
  - Owner 2 holds req for more than 15 HOLD cycles → err pulses once, gnt=0, and requester 3 (req high) is granted next.
  - Requester 2 is not re-granted until its req toggles low then high.
